// File: rtl/vga_sync_pkg.sv
// Shared 640x480@72 Hz timing defaults, counter/colour widths and the
// helper used to derive line and frame totals.
package vga_sync_pkg;
    localparam int CNT_W   = 10;
    localparam int COLOR_W = 3;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 24;
    localparam int H_SYNC_DEF   = 40;
    localparam int H_BP_DEF     = 128;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 9;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 28;

    localparam logic SYNC_POL_DEF = 1'b0;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
endpackage

// File: rtl/wrap_counter.sv
// Modulus-N up-counter with enable; wrap_o is high on the enabled clock
// where the count returns from N-1 to 0.
module wrap_counter #(
    parameter int N = 832,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap_o  = en_i && (count_q == LAST);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: h/v counters publish the pixel coordinate, and one
// register stage aligns the returned colour with hsync/vsync/frame_start.
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COLOR_W-1:0] color_px,
    output logic [CNT_W-1:0]   x_px,
    output logic [CNT_W-1:0]   y_px,
    output logic               activevideo,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             h_wrap;
    logic             v_wrap;

    wrap_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (hc),
        .wrap_o  (h_wrap)
    );

    wrap_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (h_wrap),
        .count_o (vc),
        .wrap_o  (v_wrap)
    );

    assign x_px = hc;
    assign y_px = vc;

    logic visible;
    logic hs_active;
    logic vs_active;

    assign visible   = (hc < H_VIS_END) && (vc < V_VIS_END);
    assign hs_active = (hc >= HS_FIRST) && (hc <= HS_LAST);
    assign vs_active = (vc >= VS_FIRST) && (vc <= VS_LAST);

    // High exactly when the counters sit at (0,0): after reset or a frame wrap.
    logic origin_q;

    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               active_q, active_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d;

    always_comb begin
        rgb_d         = visible ? color_px : '0;
        active_d      = visible;
        hsync_d       = hs_active ? SYNC_POL : ~SYNC_POL;
        vsync_d       = vs_active ? SYNC_POL : ~SYNC_POL;
        frame_start_d = origin_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            origin_q      <= 1'b1;
            rgb_q         <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            origin_q      <= v_wrap;
            rgb_q         <= rgb_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rgb         = rgb_q;
    assign activevideo = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
endmodule
